// File: rtl/rule_configurer_mc.sv
// rule_configurer_mc
// Decodes rule-management commands into TCAM key writes and action-RAM
// writes/reads for one of NUM_STAGES parser stages. Adds read-back with
// timeout, a sequenced clear-all of a stage TCAM and bad-stage reporting.
//
// Ports
//   clk, reset        rising-edge clock, async active-high reset
//   cmd_valid/ready   command handshake; cmd_data = {op, stage, key, action, rule}
//   tcam_valid/sel/data  TCAM write strobe, one-hot stage, {op, key, rule}
//   act_valid/sel/data   action-RAM strobe, one-hot stage, {op, action, rule}
//   act_rd_valid/data    read data returned from the selected stage
//   rsp_valid/data    one-cycle response {op, status, action, rule}
//   busy              high whenever the FSM is not idle
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | ready for a command; add/del/bad-stage finish in one cycle
// RD_WAIT  | action-RAM read issued, waiting for data or timeout
// CLEAR    | walking every TCAM index of one stage with delete strobes
module rule_configurer_mc #(
  parameter int NUM_STAGES = 4,
  parameter int STAGE_W    = 2,
  parameter int KEY_W      = 40,
  parameter int ACT_W      = 120,
  parameter int IDX_W      = 8,
  parameter int TIMEOUT    = 16
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  cmd_valid,
  output logic                                  cmd_ready,
  input  logic [2+STAGE_W+KEY_W+ACT_W+IDX_W-1:0] cmd_data,
  output logic                                  tcam_valid,
  output logic [NUM_STAGES-1:0]                 tcam_sel,
  output logic [2+KEY_W+IDX_W-1:0]              tcam_data,
  output logic                                  act_valid,
  output logic [NUM_STAGES-1:0]                 act_sel,
  output logic [2+ACT_W+IDX_W-1:0]              act_data,
  input  logic                                  act_rd_valid,
  input  logic [ACT_W-1:0]                      act_rd_data,
  output logic                                  rsp_valid,
  output logic [4+ACT_W+IDX_W-1:0]              rsp_data,
  output logic                                  busy
);

  localparam int CMD_W = 2 + STAGE_W + KEY_W + ACT_W + IDX_W;
  localparam int TCD_W = 2 + KEY_W + IDX_W;
  localparam int ACD_W = 2 + ACT_W + IDX_W;
  localparam int RSP_W = 4 + ACT_W + IDX_W;
  localparam int TMO_W = $clog2(TIMEOUT + 1);

  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  localparam logic [1:0] OP_READ  = 2'd0;
  localparam logic [1:0] OP_ADD   = 2'd1;
  localparam logic [1:0] OP_DEL   = 2'd2;
  localparam logic [1:0] OP_CLEAR = 2'd3;

  localparam logic [1:0] ST_OK      = 2'd0;
  localparam logic [1:0] ST_TIMEOUT = 2'd1;
  localparam logic [1:0] ST_BAD     = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RD_WAIT = 2'd1,
    S_CLEAR   = 2'd2
  } state_t;

  state_t state, state_nxt;

  // Command fields
  logic [1:0]            cmd_op;
  logic [STAGE_W-1:0]    cmd_stage;
  logic [KEY_W-1:0]      cmd_key;
  logic [ACT_W-1:0]      cmd_act;
  logic [IDX_W-1:0]      cmd_rule;
  logic [NUM_STAGES-1:0] cmd_sel;
  logic                  stage_bad;
  logic                  fire;

  assign cmd_op    = cmd_data[CMD_W-1 -: 2];
  assign cmd_stage = cmd_data[CMD_W-3 -: STAGE_W];
  assign cmd_key   = cmd_data[IDX_W+ACT_W +: KEY_W];
  assign cmd_act   = cmd_data[IDX_W +: ACT_W];
  assign cmd_rule  = cmd_data[IDX_W-1:0];
  assign stage_bad = (int'(cmd_stage) >= NUM_STAGES);
  assign fire      = cmd_valid && cmd_ready;

  always_comb begin
    cmd_sel = '0;
    for (int i = 0; i < NUM_STAGES; i++) begin
      if (cmd_stage == STAGE_W'(i)) cmd_sel[i] = 1'b1;
    end
  end

  // Working registers
  logic [TMO_W-1:0]      tmo_cnt, tmo_nxt;
  // One bit wider than the index so reaching 2^IDX_W marks completion.
  logic [IDX_W:0]        idx_cnt, idx_nxt;
  logic [IDX_W-1:0]      rule_q, rule_nxt;
  logic [NUM_STAGES-1:0] sel_q, sel_nxt;

  // Next values of the registered outputs
  logic                  tcam_valid_nxt, act_valid_nxt, rsp_valid_nxt;
  logic [NUM_STAGES-1:0] tcam_sel_nxt, act_sel_nxt;
  logic [TCD_W-1:0]      tcam_data_nxt;
  logic [ACD_W-1:0]      act_data_nxt;
  logic [RSP_W-1:0]      rsp_data_nxt;

  // State and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      tmo_cnt    <= '0;
      idx_cnt    <= '0;
      rule_q     <= '0;
      sel_q      <= '0;
      tcam_valid <= 1'b0;
      tcam_sel   <= '0;
      tcam_data  <= '0;
      act_valid  <= 1'b0;
      act_sel    <= '0;
      act_data   <= '0;
      rsp_valid  <= 1'b0;
      rsp_data   <= '0;
      busy       <= 1'b0;
      cmd_ready  <= 1'b0;
    end else begin
      state      <= state_nxt;
      tmo_cnt    <= tmo_nxt;
      idx_cnt    <= idx_nxt;
      rule_q     <= rule_nxt;
      sel_q      <= sel_nxt;
      tcam_valid <= tcam_valid_nxt;
      tcam_sel   <= tcam_sel_nxt;
      tcam_data  <= tcam_data_nxt;
      act_valid  <= act_valid_nxt;
      act_sel    <= act_sel_nxt;
      act_data   <= act_data_nxt;
      rsp_valid  <= rsp_valid_nxt;
      rsp_data   <= rsp_data_nxt;
      // Registered decode of the state being entered
      busy       <= (state_nxt != S_IDLE);
      cmd_ready  <= (state_nxt == S_IDLE);
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: begin
        if (fire && !stage_bad) begin
          if (cmd_op == OP_READ)       state_nxt = S_RD_WAIT;
          else if (cmd_op == OP_CLEAR) state_nxt = S_CLEAR;
        end
      end
      S_RD_WAIT: begin
        if (act_rd_valid || (tmo_cnt == TMO_LAST)) state_nxt = S_IDLE;
      end
      S_CLEAR: begin
        if (idx_cnt[IDX_W]) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output / datapath logic
  always_comb begin
    tmo_nxt        = tmo_cnt;
    idx_nxt        = idx_cnt;
    rule_nxt       = rule_q;
    sel_nxt        = sel_q;
    tcam_valid_nxt = 1'b0;
    tcam_sel_nxt   = '0;
    tcam_data_nxt  = '0;
    act_valid_nxt  = 1'b0;
    act_sel_nxt    = '0;
    act_data_nxt   = '0;
    rsp_valid_nxt  = 1'b0;
    rsp_data_nxt   = '0;
    unique case (state)
      S_IDLE: begin
        if (fire) begin
          rule_nxt = cmd_rule;
          sel_nxt  = cmd_sel;
          if (stage_bad) begin
            rsp_valid_nxt = 1'b1;
            rsp_data_nxt  = {cmd_op, ST_BAD, {ACT_W{1'b0}}, cmd_rule};
          end else begin
            unique case (cmd_op)
              OP_READ: begin
                act_valid_nxt = 1'b1;
                act_sel_nxt   = cmd_sel;
                act_data_nxt  = {OP_READ, {ACT_W{1'b0}}, cmd_rule};
                tmo_nxt       = '0;
              end
              OP_ADD: begin
                tcam_valid_nxt = 1'b1;
                tcam_sel_nxt   = cmd_sel;
                tcam_data_nxt  = {OP_ADD, cmd_key, cmd_rule};
                act_valid_nxt  = 1'b1;
                act_sel_nxt    = cmd_sel;
                act_data_nxt   = {OP_ADD, cmd_act, cmd_rule};
              end
              OP_DEL: begin
                tcam_valid_nxt = 1'b1;
                tcam_sel_nxt   = cmd_sel;
                tcam_data_nxt  = {OP_DEL, cmd_key, cmd_rule};
              end
              default: begin
                // Clear: index 0 goes out now, the walk continues from 1.
                tcam_valid_nxt = 1'b1;
                tcam_sel_nxt   = cmd_sel;
                tcam_data_nxt  = {OP_DEL, {KEY_W{1'b0}}, {IDX_W{1'b0}}};
                idx_nxt        = (IDX_W+1)'(1);
              end
            endcase
          end
        end
      end
      S_RD_WAIT: begin
        // Data arriving on the last timeout cycle still counts as success.
        if (act_rd_valid) begin
          rsp_valid_nxt = 1'b1;
          rsp_data_nxt  = {OP_READ, ST_OK, act_rd_data, rule_q};
        end else if (tmo_cnt == TMO_LAST) begin
          rsp_valid_nxt = 1'b1;
          rsp_data_nxt  = {OP_READ, ST_TIMEOUT, {ACT_W{1'b0}}, rule_q};
        end else begin
          tmo_nxt = tmo_cnt + TMO_W'(1);
        end
      end
      S_CLEAR: begin
        if (idx_cnt[IDX_W]) begin
          rsp_valid_nxt = 1'b1;
          rsp_data_nxt  = {OP_CLEAR, ST_OK, {ACT_W{1'b0}}, rule_q};
        end else begin
          tcam_valid_nxt = 1'b1;
          tcam_sel_nxt   = sel_q;
          tcam_data_nxt  = {OP_DEL, {KEY_W{1'b0}}, idx_cnt[IDX_W-1:0]};
          idx_nxt        = idx_cnt + (IDX_W+1)'(1);
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_rule_configurer_mc.sv
module tb_rule_configurer_mc;

  logic         clk = 1'b0;
  logic         reset;
  logic [171:0] cmd_data;
  logic         act_rd_valid;
  logic [119:0] act_rd_data;

  // Four-stage instance
  logic         cmd_valid, cmd_ready, tcam_valid, act_valid, rsp_valid, busy;
  logic [3:0]   tcam_sel, act_sel;
  logic [49:0]  tcam_data;
  logic [129:0] act_data;
  logic [131:0] rsp_data;

  // Three-stage instance (stage 3 is out of range)
  logic         cmd_valid3, cmd_ready3, tcam_valid3, act_valid3, rsp_valid3, busy3;
  logic [2:0]   tcam_sel3, act_sel3;
  logic [49:0]  tcam_data3;
  logic [129:0] act_data3;
  logic [131:0] rsp_data3;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  rule_configurer_mc dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_data(cmd_data),
    .tcam_valid(tcam_valid), .tcam_sel(tcam_sel), .tcam_data(tcam_data),
    .act_valid(act_valid), .act_sel(act_sel), .act_data(act_data),
    .act_rd_valid(act_rd_valid), .act_rd_data(act_rd_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy)
  );

  rule_configurer_mc #(.NUM_STAGES(3)) dut3 (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid3), .cmd_ready(cmd_ready3), .cmd_data(cmd_data),
    .tcam_valid(tcam_valid3), .tcam_sel(tcam_sel3), .tcam_data(tcam_data3),
    .act_valid(act_valid3), .act_sel(act_sel3), .act_data(act_data3),
    .act_rd_valid(act_rd_valid), .act_rd_data(act_rd_data),
    .rsp_valid(rsp_valid3), .rsp_data(rsp_data3), .busy(busy3)
  );

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] op, input logic [1:0] st, input logic [39:0] key,
                      input logic [119:0] act, input logic [7:0] rule);
    cmd_data  = {op, st, key, act, rule};
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [119:0] act_a, d_rd, d_tie;
    logic [39:0]  key_a, key_d;
    int           n, good, stray;

    act_a = 120'h00AB_CDEF_0123_4567_89AB_CDEF_0123_45;
    key_a = 40'h0A_0000_0011;
    key_d = 40'h05_1234_5678;
    d_rd  = 120'h11_2233_4455_6677_8899_AABB_CCDD_EEFF;
    d_tie = 120'h99_8877_6655_4433_2211_0000_FFEE_DDCC;

    reset = 1'b1; cmd_valid = 1'b0; cmd_valid3 = 1'b0; cmd_data = '0;
    act_rd_valid = 1'b0; act_rd_data = '0;
    tick(); tick();

    // Reset state
    chk("rst_cmd_ready", cmd_ready, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_strobes", {tcam_valid, act_valid, rsp_valid}, 3'b000);
    reset = 1'b0;
    tick();
    chk("post_rst_ready", cmd_ready, 1'b1);

    // Add
    send(2'd1, 2'd2, key_a, act_a, 8'h05);
    chk("add_tcam_valid", tcam_valid, 1'b1);
    chk("add_act_valid", act_valid, 1'b1);
    chk("add_tcam_sel", tcam_sel, 4'b0100);
    chk("add_act_sel", act_sel, 4'b0100);
    chk("add_tcam_data", tcam_data, {2'd1, key_a, 8'h05});
    chk("add_act_data", act_data, {2'd1, act_a, 8'h05});
    chk("add_no_rsp", rsp_valid, 1'b0);
    tick();
    chk("add_pulse_end", {tcam_valid, act_valid}, 2'b00);

    // Delete
    send(2'd2, 2'd3, key_d, act_a, 8'h22);
    chk("del_tcam_valid", tcam_valid, 1'b1);
    chk("del_tcam_sel", tcam_sel, 4'b1000);
    chk("del_tcam_data", tcam_data, {2'd2, key_d, 8'h22});
    chk("del_no_act", {act_valid, rsp_valid}, 2'b00);
    tick();

    // Read data in IDLE is ignored
    act_rd_valid = 1'b1; act_rd_data = d_rd;
    tick();
    act_rd_valid = 1'b0;
    chk("idle_rd_ignored", rsp_valid, 1'b0);

    // Read with data returned three cycles after the request
    send(2'd0, 2'd1, key_a, act_a, 8'h10);
    chk("rd_act_valid", act_valid, 1'b1);
    chk("rd_act_sel", act_sel, 4'b0010);
    chk("rd_act_data", act_data, {2'd0, 120'd0, 8'h10});
    chk("rd_no_tcam", tcam_valid, 1'b0);
    chk("rd_busy_ready", {busy, cmd_ready}, 2'b10);
    tick();
    tick();
    chk("rd_wait_no_rsp", {rsp_valid, cmd_ready}, 2'b00);
    act_rd_valid = 1'b1; act_rd_data = d_rd;
    tick();
    act_rd_valid = 1'b0;
    chk("rd_rsp_valid", rsp_valid, 1'b1);
    chk("rd_rsp_data", rsp_data, {2'd0, 2'd0, d_rd, 8'h10});
    chk("rd_done_ready", {busy, cmd_ready}, 2'b01);
    tick();
    chk("rd_rsp_pulse", rsp_valid, 1'b0);

    // Read timeout
    send(2'd0, 2'd0, key_a, act_a, 8'h33);
    chk("tmo_act_valid", act_valid, 1'b1);
    n = 0;
    while (!rsp_valid && n < 40) begin
      tick();
      n++;
    end
    chk("tmo_latency", n, 16);
    chk("tmo_rsp_data", rsp_data, {2'd0, 2'd1, 120'd0, 8'h33});
    tick();

    // Data on the final timeout cycle wins
    send(2'd0, 2'd3, key_a, act_a, 8'h44);
    stray = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (rsp_valid) stray++;
    end
    chk("tie_no_early_rsp", stray, 0);
    act_rd_valid = 1'b1; act_rd_data = d_tie;
    tick();
    act_rd_valid = 1'b0;
    chk("tie_rsp_valid", rsp_valid, 1'b1);
    chk("tie_rsp_data", rsp_data, {2'd0, 2'd0, d_tie, 8'h44});
    tick();

    // Clear stage 0
    send(2'd3, 2'd0, key_a, act_a, 8'h77);
    good = 0; stray = 0;
    for (int i = 0; i < 256; i++) begin
      if (tcam_valid && tcam_sel == 4'b0001 && tcam_data == {2'd2, 40'd0, 8'(i)}) good++;
      if (act_valid || rsp_valid || !busy) stray++;
      tick();
    end
    chk("clr_strobes", good, 256);
    chk("clr_no_stray", stray, 0);
    chk("clr_rsp_valid", rsp_valid, 1'b1);
    chk("clr_rsp_data", rsp_data, {2'd3, 2'd0, 120'd0, 8'h77});
    chk("clr_end_tcam", tcam_valid, 1'b0);
    tick();

    // Reset during clear at idx 37
    send(2'd3, 2'd1, key_a, act_a, 8'h55);
    for (int i = 0; i < 37; i++) tick();
    chk("clr37_idx", tcam_data, {2'd2, 40'd0, 8'd37});
    #2 reset = 1'b1;
    #1;
    chk("rst_mid_outputs", {tcam_valid, tcam_sel, act_valid, rsp_valid, busy, cmd_ready}, 9'd0);
    chk("rst_mid_data", tcam_data, 50'd0);
    tick(); tick();
    reset = 1'b0;
    stray = 0;
    tick();
    if (rsp_valid || tcam_valid) stray++;
    tick();
    if (rsp_valid || tcam_valid) stray++;
    chk("rst_no_rsp", stray, 0);
    chk("rst_ready", cmd_ready, 1'b1);
    send(2'd1, 2'd0, key_a, act_a, 8'h06);
    chk("rst_add_strobes", {tcam_valid, act_valid, tcam_sel}, 6'b11_0001);
    tick();

    // Bad stage on the three-stage instance
    cmd_data   = {2'd1, 2'd3, key_a, act_a, 8'h9A};
    cmd_valid3 = 1'b1;
    tick();
    cmd_valid3 = 1'b0;
    chk("bad_rsp_valid", rsp_valid3, 1'b1);
    chk("bad_rsp_data", rsp_data3, {2'd1, 2'd2, 120'd0, 8'h9A});
    chk("bad_no_strobe", {tcam_valid3, act_valid3}, 2'b00);
    chk("bad_stay_idle", {busy3, cmd_ready3}, 2'b01);
    tick();
    cmd_data   = {2'd1, 2'd2, key_a, act_a, 8'h9B};
    cmd_valid3 = 1'b1;
    tick();
    cmd_valid3 = 1'b0;
    chk("s3_add_sel", {tcam_valid3, tcam_sel3, rsp_valid3}, 5'b1_100_0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
